// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO nibble transfer sequencer.
//   gpio_xfer_state_t : sequencer FSM states
//   GPIO_NIB_W        : width of one GPIO data nibble
//   GPIO_DIR_TX/RX    : encoding of the transfer direction input
//   nib_shift()       : moves the next transmit nibble into the low bits
package gpio_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    GAP     = 3'd3,
    DONE    = 3'd4
  } gpio_xfer_state_t;

  localparam int   GPIO_NIB_W  = 4;
  localparam logic GPIO_DIR_TX = 1'b0;
  localparam logic GPIO_DIR_RX = 1'b1;

  // Drop the nibble just sent and zero-fill from the top.
  function automatic logic [31:0] nib_shift(input logic [31:0] word);
    return {4'b0000, word[31:4]};
  endfunction

endpackage

// File: rtl/flopenr.sv
// Resettable enabled register.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   en    : load d when high, otherwise hold
//   d / q : data in / registered data out
module flopenr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Storage element: clear on reset, load on enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= {WIDTH{1'b0}};
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gap_timer.sv
// Loadable down counter that times the idle gap between nibbles.
//   clk      : rising-edge clock
//   reset    : synchronous active-high clear
//   load     : load load_val (takes priority over en)
//   en       : decrement by one while non-zero
//   load_val : value loaded on load
//   zero     : registered flag, high while the count is zero
module gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [GAP_W-1:0] load_val,
  output logic             zero
);

  localparam logic [GAP_W-1:0] CNT_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] CNT_ONE  = GAP_W'(32'd1);

  logic [GAP_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;

  // Next count; the zero flag is computed from the next count so it is
  // already valid in the first cycle after a load.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != CNT_ZERO)) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
    zero_d = (count_d == CNT_ZERO);
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= CNT_ZERO;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/gpio_xfer_ctrl.sv
// Sequencer that moves a 32-bit word over the 4-bit memory-mapped GPIO port
// as NIBBLES nibble operations (LSB nibble first) with a GAP-cycle idle
// period between nibbles.
//   clk, reset            : clock, synchronous active-high reset
//   start, dir, tx_word   : command from the CPU side, sampled in IDLE
//   abort                 : cancel an in-flight transfer (no done)
//   busy, done, rx_word   : status and assembled receive word
//   gpio_enable/memwrite  : strobes to the GPIO instance
//   gpio_wd               : {28'b0, current transmit nibble}
//   gpio_rd               : GPIO read data, only [3:0] is meaningful
module gpio_xfer_ctrl
  import gpio_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter int GAP     = 4,
  parameter int GAP_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic        abort,
  input  logic [31:0] tx_word,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_word,
  output logic        gpio_enable,
  output logic        gpio_memwrite,
  output logic [31:0] gpio_wd,
  input  logic [31:0] gpio_rd
);

  localparam int               IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 32'sd1);
  localparam bit               GAP_NONE = (GAP == 32'sd0);
  // The GAP state is left when the counter reads zero, so loading GAP-1
  // yields exactly GAP idle cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 32'sd0) ? GAP_W'(GAP - 32'sd1)
                                                         : {GAP_W{1'b0}};

  gpio_xfer_state_t state_q, state_d;
  logic             dir_q, dir_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             enable_q, enable_d;
  logic             memwrite_q, memwrite_d;

  logic             load_s;
  logic             shift_en_s;
  logic             cap_en_s;
  logic             gap_load_s;
  logic             gap_en_s;
  logic             gap_zero_s;
  logic [31:0]      shift_d;
  logic [31:0]      shift_q;
  logic [NIBBLES*GPIO_NIB_W-1:0] rx_q;
  logic             rd_unused_s;

  // Next-state and next-output logic. Outputs are derived from the next
  // state so that the registered strobes line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    idx_d      = idx_q;
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    cap_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          dir_d   = dir;
          idx_d   = IDX_ZERO;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = IDX_ZERO;
        end else if (dir_q == GPIO_DIR_TX) begin
          // GPIO latches wd at the end of this cycle; present the next nibble.
          shift_en_s = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else if (GAP_NONE) begin
            state_d = ISSUE;
            idx_d   = idx_q + IDX_ONE;
          end else begin
            state_d = gpio_pkg::GAP;
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = IDX_ZERO;
        end else begin
          // GPIO registered gpi at the end of ISSUE, so rd is valid now.
          cap_en_s = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else if (GAP_NONE) begin
            state_d = ISSUE;
            idx_d   = idx_q + IDX_ONE;
          end else begin
            state_d = gpio_pkg::GAP;
          end
        end
      end
      gpio_pkg::GAP: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = IDX_ZERO;
        end else if (gap_zero_s) begin
          state_d = ISSUE;
          idx_d   = idx_q + IDX_ONE;
        end else begin
          state_d = gpio_pkg::GAP;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = IDX_ZERO;
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDX_ZERO;
      end
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    enable_d   = (state_d == ISSUE);
    memwrite_d = enable_d && (dir_d != GPIO_DIR_RX);
  end

  // Gap counter is loaded on entry to GAP and runs only while in GAP.
  always_comb begin
    gap_load_s = (state_d == gpio_pkg::GAP) && (state_q != gpio_pkg::GAP);
    gap_en_s   = (state_q == gpio_pkg::GAP);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= GPIO_DIR_TX;
      idx_q      <= IDX_ZERO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      enable_q   <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      enable_q   <= enable_d;
      memwrite_q <= memwrite_d;
    end
  end

  gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load_s),
    .en       (gap_en_s),
    .load_val (GAP_LOAD),
    .zero     (gap_zero_s)
  );

  // Transmit shift register: loaded at start, shifted after each issue.
  assign shift_d = load_s ? tx_word : nib_shift(shift_q);

  flopenr #(
    .WIDTH (32)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .en    (load_s | shift_en_s),
    .d     (shift_d),
    .q     (shift_q)
  );

  // One nibble register per position; untouched nibbles keep their value,
  // which is what leaves a partial word visible after an abort.
  for (genvar i = 0; i < NIBBLES; i++) begin : g_rx_nib
    flopenr #(
      .WIDTH (GPIO_NIB_W)
    ) u_rx_nib (
      .clk   (clk),
      .reset (reset),
      .en    (cap_en_s && (idx_q == IDX_W'(i))),
      .d     (gpio_rd[GPIO_NIB_W-1:0]),
      .q     (rx_q[GPIO_NIB_W*i +: GPIO_NIB_W])
    );
  end

  assign rd_unused_s   = ^gpio_rd[31:GPIO_NIB_W];

  assign busy          = busy_q;
  assign done          = done_q;
  assign gpio_enable   = enable_q;
  assign gpio_memwrite = memwrite_q;
  assign gpio_wd       = {{(32-GPIO_NIB_W){1'b0}}, shift_q[GPIO_NIB_W-1:0]};
  assign rx_word       = rx_q;

endmodule
